z_core_mdu: RTL and testbench

//  Iterative RV32M multiply/divide unit; the sequential companion to the single-cycle z_core_alu.

---
 rtl/z_core_pkg.sv | 22 ++
 rtl/z_core_mdu_step.sv | 32 +++
 rtl/z_core_mdu.sv | 139 +++++++++++++
 tb/tb_z_core_mdu.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/z_core_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes, opcode fields, FSM states.
package z_core_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/z_core_mdu_step.sv
// One iteration of the MDU datapath on a {hi,lo} register pair:
// shift-add (multiply, LSB first) or restoring trial-subtract (divide, MSB first).
module z_core_mdu_step #(
    parameter int XLEN = 32
) (
    input  logic            i_div,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_shift;
    logic          w_ge;

    always_comb begin
        w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
        w_shift = {i_hi, i_lo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, i_b});
        if (i_div) begin
            // partial remainder stays below the divisor, so XLEN bits suffice
            o_hi = w_ge ? (w_shift[XLEN-1:0] - i_b) : w_shift[XLEN-1:0];
            o_lo = {i_lo[XLEN-2:0], w_ge};
        end else begin
            o_hi = w_sum[XLEN:1];
            o_lo = {w_sum[0], i_lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/z_core_mdu.sv
// Iterative RV32M multiply/divide unit, one bit per cycle, with start/ready/done handshake.
//   state | meaning
//   IDLE  | ready; accepts a request, resolves div-by-zero / overflow directly
//   CALC  | XLEN magnitude iterations through z_core_mdu_step
//   DONE  | one-cycle result pulse, then back to IDLE
module z_core_mdu
    import z_core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mdu_start,
    input  logic            mdu_flush,
    input  logic [2:0]      mdu_funct3,
    input  logic [XLEN-1:0] mdu_in1,
    input  logic [XLEN-1:0] mdu_in2,
    output logic            mdu_ready,
    output logic            mdu_busy,
    output logic            mdu_done,
    output logic [XLEN-1:0] mdu_out
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        r_state, w_state_n;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_hi, r_lo, r_b, r_res, r_out;
    logic              r_neg, r_neg_r;

    logic              w_accept, w_special, w_last, w_sa, w_sb;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_spec_res, w_hi_n, w_lo_n, w_quo, w_rem, w_final;
    logic [2*XLEN-1:0] w_prod;

    z_core_mdu_step #(.XLEN(XLEN)) u_step (
        .i_div (r_f3[2]),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .i_b   (r_b),
        .o_hi  (w_hi_n),
        .o_lo  (w_lo_n)
    );

    always_comb begin
        w_sa = 1'b0;
        w_sb = 1'b0;
        case (mdu_funct3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin w_sa = 1'b1; w_sb = 1'b1; end
            F3_MULHSU:                       w_sa = 1'b1;
            default:                         ;
        endcase
        w_abs_a   = (w_sa && mdu_in1[XLEN-1]) ? -mdu_in1 : mdu_in1;
        w_abs_b   = (w_sb && mdu_in2[XLEN-1]) ? -mdu_in2 : mdu_in2;
        w_accept  = mdu_start && !mdu_flush && (r_state == ST_IDLE);
        w_special = 1'b0;
        w_spec_res = '0;
        if (mdu_funct3[2]) begin
            if (mdu_in2 == '0) begin
                w_special  = 1'b1;
                w_spec_res = mdu_funct3[1] ? mdu_in1 : '1;
            end else if (w_sa && mdu_in1 == MIN_NEG && mdu_in2 == '1) begin
                w_special  = 1'b1;
                w_spec_res = mdu_funct3[1] ? '0 : mdu_in1;
            end
        end
    end

    always_comb begin
        w_last = (r_cnt == CNT_W'(1));
        w_prod = {w_hi_n, w_lo_n};
        if (r_neg) w_prod = -w_prod;
        w_quo = r_neg   ? -w_lo_n : w_lo_n;
        w_rem = r_neg_r ? -w_hi_n : w_hi_n;
        case (r_f3)
            F3_MUL:                      w_final = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             w_final = w_quo;
            default:                     w_final = w_rem;
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_n = w_special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (mdu_flush)   w_state_n = ST_IDLE;
                else if (w_last) w_state_n = ST_DONE;
            end
            ST_DONE: w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_f3    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_neg   <= 1'b0;
            r_neg_r <= 1'b0;
            r_res   <= '0;
            r_out   <= '0;
        end else begin
            if (w_accept) begin
                r_f3    <= mdu_funct3;
                r_hi    <= '0;
                r_lo    <= w_abs_a;
                r_b     <= w_abs_b;
                r_neg   <= (w_sa & mdu_in1[XLEN-1]) ^ (w_sb & mdu_in2[XLEN-1]);
                r_neg_r <= w_sa & mdu_in1[XLEN-1];
                r_cnt   <= CNT_W'(XLEN);
                if (w_special) r_res <= w_spec_res;
            end else if (r_state == ST_CALC && !mdu_flush) begin
                r_hi  <= w_hi_n;
                r_lo  <= w_lo_n;
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_last) r_res <= w_final;
            end
            // result is only committed when the DONE cycle survives a flush
            if (r_state == ST_DONE && !mdu_flush) r_out <= r_res;
        end
    end

    assign mdu_ready = (r_state == ST_IDLE);
    assign mdu_busy  = (r_state == ST_CALC) || (r_state == ST_DONE);
    assign mdu_done  = (r_state == ST_DONE) && !mdu_flush;
    assign mdu_out   = mdu_done ? r_res : r_out;

endmodule

// File: tb/tb_z_core_mdu.sv
// Directed and randomized checks of z_core_mdu: latency, results, special cases, flush, reset.
module tb_z_core_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mdu_start, mdu_flush;
    logic [2:0]  mdu_funct3;
    logic [31:0] mdu_in1, mdu_in2;
    logic        mdu_ready, mdu_busy, mdu_done;
    logic [31:0] mdu_out;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    z_core_mdu #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mdu_start  (mdu_start),
        .mdu_flush  (mdu_flush),
        .mdu_funct3 (mdu_funct3),
        .mdu_in1    (mdu_in1),
        .mdu_in2    (mdu_in2),
        .mdu_ready  (mdu_ready),
        .mdu_busy   (mdu_busy),
        .mdu_done   (mdu_done),
        .mdu_out    (mdu_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Call at a negedge with the unit idle; returns at the negedge where done is seen.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        mdu_funct3 = f3; mdu_in1 = a; mdu_in2 = b; mdu_start = 1'b1;
        @(posedge clk); #1;
        mdu_start = 1'b0; mdu_funct3 = ~f3; mdu_in1 = ~a; mdu_in2 = ~b;
        lat = 0; res = '0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (mdu_done) begin lat = i; res = mdu_out; break; end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", mdu_ready); end
        n_cmp++; if (mdu_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", mdu_busy); end
        n_cmp++; if (mdu_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", mdu_done); end
        n_cmp++; if (mdu_out !== 32'h0) begin n_err++; $display("FAIL reset_out: got %h expected 00000000", mdu_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul_latency;
        int lat, bad_ready;
        logic [31:0] res;
        mdu_funct3 = 3'd0; mdu_in1 = 32'd7; mdu_in2 = 32'hFFFF_FFFD; mdu_start = 1'b1;
        @(posedge clk); #1;
        mdu_start = 1'b0; mdu_funct3 = 3'd7; mdu_in1 = '0; mdu_in2 = '0;
        lat = 0; res = '0; bad_ready = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i <= 33 && mdu_ready) bad_ready++;
            if (mdu_done) begin lat = i; res = mdu_out; break; end
        end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_latency: got %0d expected 33", lat); end
        n_cmp++; if (res !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_result: got %h expected ffffffeb", res); end
        n_cmp++; if (bad_ready !== 0) begin n_err++; $display("FAIL mul_ready_low: got %0d high cycles expected 0", bad_ready); end
        @(negedge clk);
        n_cmp++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL mul_ready_back: got %b expected 1", mdu_ready); end
        n_cmp++; if (mdu_busy !== 1'b0) begin n_err++; $display("FAIL mul_busy_after: got %b expected 0", mdu_busy); end
        n_cmp++; if (mdu_out !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_out_hold: got %h expected ffffffeb", mdu_out); end
    endtask

    task automatic test_mul_high;
        logic [2:0]  f3s [3] = '{3'd1, 3'd3, 3'd2};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exs [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(f3s[i], as[i], bs[i], res, lat);
            n_cmp++; if (res !== exs[i]) begin n_err++; $display("FAIL mulh_%0d: got %h expected %h", i, res, exs[i]); end
            n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mulh_lat_%0d: got %0d expected 33", i, lat); end
            @(negedge clk);
        end
    endtask

    task automatic test_div;
        logic [2:0]  f3s [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exs [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(f3s[i], as[i], bs[i], res, lat);
            n_cmp++; if (res !== exs[i]) begin n_err++; $display("FAIL div_%0d: got %h expected %h", i, res, exs[i]); end
            n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL div_lat_%0d: got %0d expected 33", i, lat); end
            @(negedge clk);
        end
    endtask

    task automatic test_special;
        logic [2:0]  f3s [5] = '{3'd5, 3'd6, 3'd4, 3'd7, 3'd4};
        logic [31:0] as  [5] = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'h1234, 32'hFFFF_FFFB};
        logic [31:0] bs  [5] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] exs [5] = '{32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'h1234, 32'hFFFF_FFFF};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(f3s[i], as[i], bs[i], res, lat);
            n_cmp++; if (res !== exs[i]) begin n_err++; $display("FAIL special_%0d: got %h expected %h", i, res, exs[i]); end
            n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL special_lat_%0d: got %0d expected 1", i, lat); end
            @(negedge clk);
        end
    endtask

    task automatic test_flush;
        logic [31:0] res;
        int lat, seen;
        run_op(3'd5, 32'd100, 32'd7, res, lat);
        n_cmp++; if (res !== 32'd14) begin n_err++; $display("FAIL flush_setup: got %h expected 0000000e", res); end
        @(negedge clk);
        // flush in CALC
        mdu_funct3 = 3'd3; mdu_in1 = 32'hFFFF_FFFF; mdu_in2 = 32'hFFFF_FFFF; mdu_start = 1'b1;
        @(posedge clk); #1; mdu_start = 1'b0;
        seen = 0;
        for (int i = 1; i <= 10; i++) begin @(negedge clk); if (mdu_done) seen++; end
        mdu_flush = 1'b1;
        @(posedge clk); #1; mdu_flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL flush_calc_ready: got %b expected 1", mdu_ready); end
        n_cmp++; if (mdu_busy !== 1'b0) begin n_err++; $display("FAIL flush_calc_busy: got %b expected 0", mdu_busy); end
        n_cmp++; if (mdu_out !== 32'd14) begin n_err++; $display("FAIL flush_calc_out: got %h expected 0000000e", mdu_out); end
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (mdu_done) seen++; end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL flush_calc_nodone: got %0d pulses expected 0", seen); end
        // flush in DONE
        mdu_funct3 = 3'd5; mdu_in1 = 32'd9; mdu_in2 = 32'd0; mdu_start = 1'b1;
        @(posedge clk); #1; mdu_start = 1'b0;
        @(negedge clk);
        mdu_flush = 1'b1; #1;
        n_cmp++; if (mdu_done !== 1'b0) begin n_err++; $display("FAIL flush_done_pulse: got %b expected 0", mdu_done); end
        n_cmp++; if (mdu_out !== 32'd14) begin n_err++; $display("FAIL flush_done_out: got %h expected 0000000e", mdu_out); end
        @(posedge clk); #1; mdu_flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL flush_done_ready: got %b expected 1", mdu_ready); end
        n_cmp++; if (mdu_out !== 32'd14) begin n_err++; $display("FAIL flush_done_out_after: got %h expected 0000000e", mdu_out); end
        // flush and start together in IDLE
        mdu_funct3 = 3'd5; mdu_in1 = 32'd100; mdu_in2 = 32'd7; mdu_start = 1'b1; mdu_flush = 1'b1;
        @(posedge clk); #1; mdu_start = 1'b0; mdu_flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (mdu_busy !== 1'b0) begin n_err++; $display("FAIL flush_start_busy: got %b expected 0", mdu_busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (mdu_done) seen++; end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL flush_start_nodone: got %0d pulses expected 0", seen); end
    endtask

    task automatic test_ignore_start;
        logic [31:0] res;
        int lat;
        mdu_funct3 = 3'd5; mdu_in1 = 32'd100; mdu_in2 = 32'd7; mdu_start = 1'b1;
        @(posedge clk); #1; mdu_start = 1'b0;
        lat = 0; res = '0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 5) begin mdu_start = 1'b1; mdu_funct3 = 3'd0; mdu_in1 = 32'd1000; mdu_in2 = 32'd3; end
            if (i == 8) mdu_start = 1'b0;
            if (mdu_done) begin lat = i; res = mdu_out; break; end
        end
        n_cmp++; if (res !== 32'd14) begin n_err++; $display("FAIL ignore_start_result: got %h expected 0000000e", res); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL ignore_start_lat: got %0d expected 33", lat); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (mdu_busy !== 1'b0) begin n_err++; $display("FAIL ignore_start_queued: got busy %b expected 0", mdu_busy); end
    endtask

    task automatic test_rst_mid;
        int seen;
        mdu_funct3 = 3'd0; mdu_in1 = 32'd7; mdu_in2 = 32'd9; mdu_start = 1'b1;
        @(posedge clk); #1; mdu_start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b expected 1", mdu_ready); end
        n_cmp++; if (mdu_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", mdu_busy); end
        n_cmp++; if (mdu_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b expected 0", mdu_done); end
        n_cmp++; if (mdu_out !== 32'h0) begin n_err++; $display("FAIL rst_mid_out: got %h expected 00000000", mdu_out); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (mdu_done) seen++; end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_mid_nodone: got %0d pulses expected 0", seen); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  f3;
        logic [31:0] a, b, res, exp;
        int lat, prev;
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (i % 3 == 0) b = b >> $urandom_range(0, 31);
            if (i % 4 == 1) a = a >> $urandom_range(0, 31);
            if (f3[2] && b == 0) b = 32'd1;
            if (f3[2] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            exp = ref_mdu(f3, a, b);
            @(negedge clk);
            n_cmp++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, mdu_ready); end
            run_op(f3, a, b, res, lat);
            n_cmp++; if (res !== exp) begin n_err++; $display("FAIL b2b_result_%0d f3=%0d a=%h b=%h: got %h expected %h", i, f3, a, b, res, exp); end
            if (i > 0) begin
                n_cmp++; if (cyc - prev !== 34) begin n_err++; $display("FAIL b2b_spacing_%0d: got %0d expected 34", i, cyc - prev); end
            end
            prev = cyc;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mdu_start = 1'b0; mdu_flush = 1'b0;
        mdu_funct3 = 3'd0; mdu_in1 = '0; mdu_in2 = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_mul_latency();
        @(negedge clk);
        test_mul_high();
        test_div();
        test_special();
        test_flush();
        @(negedge clk);
        test_ignore_start();
        @(negedge clk);
        test_rst_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
